// File: rtl/tcp_notify_router.sv
// tcp_notify_router
//   Routes receive notifications from the TCP offload stack to the vFPGA
//   region that owns the destination port. The owner comes from the TCP port
//   table read port. A notification whose port has no listener is dropped,
//   and the drop is counted.
//
//   Only one notification is in flight at a time, so notifications are never
//   reordered. Backpressure from any region stalls the whole router; this
//   head-of-line blocking is intended.
//
// Ports
//   aclk, aresetn        clock; synchronous active-low reset
//   s_notify_valid/ready/data
//                        notification from the stack; dst_port is taken
//                        from data[DST_PORT_LSB +: TCP_IP_PORT_BITS]
//   m_notify_valid[i], m_notify_ready[i], m_notify_data slice i
//                        per-region notification channel. Region i's data
//                        is m_notify_data[i*NOTIFY_BITS +: NOTIFY_BITS]
//   port_addr            port-table lookup address (the buffered dst_port)
//   rsid_out             port-table result, LKUP_LAT cycles after port_addr:
//                        [N_REGIONS_BITS] = valid, [N_REGIONS_BITS-1:0] = vfid
//   drop_pulse           one-cycle pulse per dropped notification
//   drop_cnt             saturating count of dropped notifications
module tcp_notify_router #(
  parameter int N_REGIONS        = 3,
  parameter int LKUP_LAT         = 2,
  parameter int PT_ADDR_BITS     = 10,
  parameter int NOTIFY_BITS      = 64,
  parameter int DST_PORT_LSB     = 32,
  parameter int TCP_IP_PORT_BITS = 16,
  localparam int N_REGIONS_BITS  = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1,
  localparam int TCP_PORT_TABLE_DATA_BITS = N_REGIONS_BITS + 1
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic                                s_notify_valid,
  output logic                                s_notify_ready,
  input  logic [NOTIFY_BITS-1:0]              s_notify_data,
  output logic [N_REGIONS-1:0]                m_notify_valid,
  input  logic [N_REGIONS-1:0]                m_notify_ready,
  output logic [N_REGIONS*NOTIFY_BITS-1:0]    m_notify_data,
  output logic [TCP_IP_PORT_BITS-1:0]         port_addr,
  input  logic [TCP_PORT_TABLE_DATA_BITS-1:0] rsid_out,
  output logic                                drop_pulse,
  output logic [31:0]                         drop_cnt
);

  localparam int CNT_BITS = (LKUP_LAT > 0) ? $clog2(LKUP_LAT + 1) : 1;
  localparam logic [CNT_BITS-1:0]       CNT_LAST    = LKUP_LAT[CNT_BITS-1:0];
  localparam logic [N_REGIONS_BITS:0]   N_REGIONS_L = N_REGIONS[N_REGIONS_BITS:0];

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LKUP = 2'd1,
    ST_FWD  = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  state_t                           state_r;
  logic [NOTIFY_BITS-1:0]           buf_r;
  logic [N_REGIONS_BITS-1:0]        vfid_r;
  logic [CNT_BITS-1:0]              cnt_r;
  logic                             s_ready_r;
  logic [N_REGIONS-1:0]             m_valid_r;
  logic [N_REGIONS*NOTIFY_BITS-1:0] m_data_r;
  logic                             drop_pulse_r;
  logic [31:0]                      drop_cnt_r;

  logic [TCP_IP_PORT_BITS-1:0]      buf_port_s;
  logic                             rsid_valid_s;
  logic [N_REGIONS_BITS-1:0]        rsid_vfid_s;
  logic                             hit_s;
  logic                             fwd_done_s;

  // One-hot select of the region addressed by idx.
  function automatic logic [N_REGIONS-1:0] region_onehot(input logic [N_REGIONS_BITS-1:0] idx);
    logic [N_REGIONS-1:0] oh;
    oh = {N_REGIONS{1'b0}};
    for (int i = 0; i < N_REGIONS; i++) begin
      if (idx == i[N_REGIONS_BITS-1:0]) begin
        oh[i] = 1'b1;
      end else begin
        oh[i] = 1'b0;
      end
    end
    return oh;
  endfunction

  // Place the notification on the selected region's slice; all other slices are zero.
  function automatic logic [N_REGIONS*NOTIFY_BITS-1:0] region_fanout(
    input logic [N_REGIONS-1:0]   oh,
    input logic [NOTIFY_BITS-1:0] d
  );
    logic [N_REGIONS*NOTIFY_BITS-1:0] out;
    out = {(N_REGIONS*NOTIFY_BITS){1'b0}};
    for (int i = 0; i < N_REGIONS; i++) begin
      if (oh[i]) begin
        out[i*NOTIFY_BITS +: NOTIFY_BITS] = d;
      end else begin
        out[i*NOTIFY_BITS +: NOTIFY_BITS] = {NOTIFY_BITS{1'b0}};
      end
    end
    return out;
  endfunction

  // Lookup address and table result decode.
  always_comb begin
    buf_port_s   = buf_r[DST_PORT_LSB +: TCP_IP_PORT_BITS];
    // The low PT_ADDR_BITS index the table; the upper bits pass through
    // unchanged and the table ignores them.
    port_addr    = {buf_port_s[TCP_IP_PORT_BITS-1:PT_ADDR_BITS], buf_port_s[PT_ADDR_BITS-1:0]};
    rsid_valid_s = rsid_out[N_REGIONS_BITS];
    rsid_vfid_s  = rsid_out[N_REGIONS_BITS-1:0];
    // A valid entry that names a region which does not exist counts as a miss.
    hit_s        = rsid_valid_s && ({1'b0, rsid_vfid_s} < N_REGIONS_L);
    // Only the active region has valid set, so masking avoids a variable index.
    fwd_done_s   = |(m_valid_r & m_notify_ready);
  end

  // Router FSM. All outputs come straight from registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r      <= ST_IDLE;
      buf_r        <= {NOTIFY_BITS{1'b0}};
      vfid_r       <= {N_REGIONS_BITS{1'b0}};
      cnt_r        <= {CNT_BITS{1'b0}};
      s_ready_r    <= 1'b0;
      m_valid_r    <= {N_REGIONS{1'b0}};
      m_data_r     <= {(N_REGIONS*NOTIFY_BITS){1'b0}};
      drop_pulse_r <= 1'b0;
      drop_cnt_r   <= 32'd0;
    end else begin
      drop_pulse_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (s_notify_valid && s_ready_r) begin
            buf_r     <= s_notify_data;
            cnt_r     <= {CNT_BITS{1'b0}};
            s_ready_r <= 1'b0;
            state_r   <= ST_LKUP;
          end else begin
            s_ready_r <= 1'b1;
          end
        end
        ST_LKUP: begin
          // rsid_out reflects this notification's port once cnt_r reaches LKUP_LAT.
          if (cnt_r == CNT_LAST) begin
            if (hit_s) begin
              vfid_r    <= rsid_vfid_s;
              m_valid_r <= region_onehot(rsid_vfid_s);
              m_data_r  <= region_fanout(region_onehot(rsid_vfid_s), buf_r);
              state_r   <= ST_FWD;
            end else begin
              drop_pulse_r <= 1'b1;
              state_r      <= ST_DROP;
            end
          end else begin
            cnt_r <= cnt_r + CNT_BITS'(1'b1);
          end
        end
        ST_FWD: begin
          // Valid and data hold until the selected region accepts.
          if (fwd_done_s) begin
            m_valid_r <= {N_REGIONS{1'b0}};
            m_data_r  <= {(N_REGIONS*NOTIFY_BITS){1'b0}};
            s_ready_r <= 1'b1;
            state_r   <= ST_IDLE;
          end else begin
            m_valid_r <= m_valid_r;
            m_data_r  <= m_data_r;
          end
        end
        ST_DROP: begin
          if (drop_cnt_r != 32'hFFFF_FFFF) begin
            drop_cnt_r <= drop_cnt_r + 32'd1;
          end else begin
            drop_cnt_r <= drop_cnt_r;
          end
          s_ready_r <= 1'b1;
          state_r   <= ST_IDLE;
        end
        default: begin
          m_valid_r <= {N_REGIONS{1'b0}};
          m_data_r  <= {(N_REGIONS*NOTIFY_BITS){1'b0}};
          s_ready_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_notify_ready = s_ready_r;
  assign m_notify_valid = m_valid_r;
  assign m_notify_data  = m_data_r;
  assign drop_pulse     = drop_pulse_r;
  assign drop_cnt       = drop_cnt_r;

endmodule

// File: tb/tb_tcp_notify_router.sv
// Directed bench for tcp_notify_router with a 3-region fanout and 2-cycle table.
// The table model maps ports as follows:
//   5001 -> valid, vfid 1
//   7000 -> valid, vfid 0
//   8000 -> valid, vfid 3 (out of range)
//   every other port -> no entry
// A notification is {sid[15:0], dst_port[15:0], len[31:0]}.
module tb_tcp_notify_router;
  localparam int NR = 3;
  localparam int NB = 64;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [NB-1:0]   s_data = '0;
  logic [NR-1:0]   m_valid;
  logic [NR-1:0]   m_ready = 3'b111;
  logic [NR*NB-1:0] m_data;
  logic [15:0]     port_addr;
  logic [2:0]      rsid_out;
  logic [2:0]      pipe1;
  logic            drop_pulse;
  logic [31:0]     drop_cnt;

  int cycle = 0;
  int vectors = 0;
  int miscompares = 0;

  tcp_notify_router #(
    .N_REGIONS(NR), .LKUP_LAT(2), .PT_ADDR_BITS(10),
    .NOTIFY_BITS(NB), .DST_PORT_LSB(32), .TCP_IP_PORT_BITS(16)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_notify_valid(s_valid), .s_notify_ready(s_ready), .s_notify_data(s_data),
    .m_notify_valid(m_valid), .m_notify_ready(m_ready), .m_notify_data(m_data),
    .port_addr(port_addr), .rsid_out(rsid_out),
    .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cycle <= cycle + 1;

  function automatic logic [2:0] tbl(input logic [15:0] p);
    case (p)
      16'd5001: return 3'b101;
      16'd7000: return 3'b100;
      16'd8000: return 3'b111;
      default:  return 3'b000;
    endcase
  endfunction

  // Port table with a two-cycle registered read.
  always @(posedge aclk) begin
    pipe1    <= tbl(port_addr);
    rsid_out <= pipe1;
  end

  function automatic logic [NB-1:0] mk(input logic [15:0] sid, input logic [15:0] p, input logic [31:0] len);
    return {sid, p, len};
  endfunction

  function automatic logic [NR*NB-1:0] exp_out(input int r, input logic [NB-1:0] d);
    logic [NR*NB-1:0] o;
    o = '0;
    o[r*NB +: NB] = d;
    return o;
  endfunction

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_to(input int t);
    while (cycle < t) @(negedge aclk);
  endtask

  // Present d at a negedge and wait (bounded) for ready. t is the handshake cycle.
  task automatic send(input logic [NB-1:0] d, output int t);
    int g;
    s_valid = 1'b1;
    s_data  = d;
    g = 0;
    while (s_ready !== 1'b1 && g < 40) begin
      @(negedge aclk);
      g++;
    end
    check("accept_wait", 192'(g < 40), 192'(1));
    t = cycle;
    @(negedge aclk);
    s_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t, t2, prev, ta, g, r;
    int exp_drop;
    logic [2:0] e;
    logic hit;
    logic [15:0] ports [10];
    logic [NB-1:0] d;

    exp_drop = 0;
    ports = '{16'd5001, 16'd7000, 16'd6000, 16'd5001, 16'd7000,
              16'd5001, 16'd6000, 16'd7000, 16'd5001, 16'd7000};

    // ---- reset values
    repeat (3) @(negedge aclk);
    check("rst_ready", 192'(s_ready), 192'(0));
    check("rst_mvalid", 192'(m_valid), 192'(0));
    check("rst_mdata", 192'(m_data), 192'(0));
    check("rst_port_addr", 192'(port_addr), 192'(0));
    check("rst_drop_pulse", 192'(drop_pulse), 192'(0));
    check("rst_drop_cnt", 192'(drop_cnt), 192'(0));
    aresetn = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    check("idle_ready", 192'(s_ready), 192'(1));

    // ---- hit forward: 5001 -> region 1, visible at T+4
    d = mk(16'h00A1, 16'd5001, 32'h1111_2222);
    send(d, t);
    check("hit_port_addr", 192'(port_addr), 192'(16'd5001));
    check("hit_ready_busy", 192'(s_ready), 192'(0));
    check("hit_mvalid_t1", 192'(m_valid), 192'(0));
    wait_to(t + 3);
    check("hit_mvalid_t3", 192'(m_valid), 192'(0));
    wait_to(t + 4);
    check("hit_mvalid_t4", 192'(m_valid), 192'(3'b010));
    check("hit_mdata_t4", 192'(m_data), 192'(exp_out(1, d)));
    check("hit_no_drop", 192'(drop_pulse), 192'(0));
    wait_to(t + 5);
    check("hit_mvalid_t5", 192'(m_valid), 192'(0));
    check("hit_mdata_t5", 192'(m_data), 192'(0));
    check("hit_ready_t5", 192'(s_ready), 192'(1));
    check("hit_drop_cnt", 192'(drop_cnt), 192'(exp_drop));

    // ---- miss drop: 6000 unlisted
    d = mk(16'h00B2, 16'd6000, 32'h3333_4444);
    send(d, t);
    wait_to(t + 3);
    check("miss_pulse_t3", 192'(drop_pulse), 192'(0));
    wait_to(t + 4);
    check("miss_pulse_t4", 192'(drop_pulse), 192'(1));
    check("miss_mvalid_t4", 192'(m_valid), 192'(0));
    exp_drop++;
    wait_to(t + 5);
    check("miss_pulse_t5", 192'(drop_pulse), 192'(0));
    check("miss_drop_cnt", 192'(drop_cnt), 192'(exp_drop));
    check("miss_mvalid_t5", 192'(m_valid), 192'(0));
    d = mk(16'h00C3, 16'd7000, 32'h5555_6666);
    send(d, t2);
    check("miss_next_accept", 192'(t2 - t), 192'(5));
    wait_to(t2 + 4);
    check("miss_next_mvalid", 192'(m_valid), 192'(3'b001));
    check("miss_next_mdata", 192'(m_data), 192'(exp_out(0, d)));
    wait_to(t2 + 5);

    // ---- backpressure on region 0 for 10 cycles
    m_ready = 3'b110;
    d = mk(16'h00D4, 16'd7000, 32'h7777_8888);
    send(d, t);
    for (int k = 4; k <= 13; k++) begin
      wait_to(t + k);
      check("bp_mvalid", 192'(m_valid), 192'(3'b001));
      check("bp_mdata", 192'(m_data), 192'(exp_out(0, d)));
      check("bp_ready", 192'(s_ready), 192'(0));
    end
    wait_to(t + 14);
    m_ready = 3'b111;
    check("bp_release_mvalid", 192'(m_valid), 192'(3'b001));
    wait_to(t + 15);
    check("bp_done_mvalid", 192'(m_valid), 192'(0));
    check("bp_done_ready", 192'(s_ready), 192'(1));

    // ---- back-to-back mix with valid held
    s_valid = 1'b1;
    s_data  = mk(16'h0400, ports[0], 32'hC0DE_0000);
    prev = 0;
    for (int k = 0; k < 10; k++) begin
      g = 0;
      while (s_ready !== 1'b1 && g < 40) begin
        @(negedge aclk);
        g++;
      end
      check("b2b_wait", 192'(g < 40), 192'(1));
      ta = cycle;
      if (k > 0) check("b2b_spacing", 192'(ta - prev), 192'(5));
      prev = ta;
      d = s_data;
      e = tbl(ports[k]);
      hit = e[2] && (e[1:0] < 2'd3);
      r = int'(e[1:0]);
      wait_to(ta + 4);
      if (hit) begin
        check("b2b_mvalid", 192'(m_valid), 192'(3'b001 << r));
        check("b2b_mdata", 192'(m_data), 192'(exp_out(r, d)));
        check("b2b_no_drop", 192'(drop_pulse), 192'(0));
      end else begin
        exp_drop++;
        check("b2b_drop_pulse", 192'(drop_pulse), 192'(1));
        check("b2b_drop_mvalid", 192'(m_valid), 192'(0));
      end
      @(negedge aclk);
      if (k < 9) s_data = mk(16'h0401 + 16'(k), ports[k + 1], 32'hC0DE_0001 + 32'(k));
      else s_valid = 1'b0;
    end
    check("b2b_drop_cnt", 192'(drop_cnt), 192'(exp_drop));

    // ---- out-of-range vfid is dropped
    d = mk(16'h00E5, 16'd8000, 32'h9999_AAAA);
    send(d, t);
    wait_to(t + 4);
    check("oor_drop_pulse", 192'(drop_pulse), 192'(1));
    check("oor_mvalid", 192'(m_valid), 192'(0));
    exp_drop++;
    wait_to(t + 5);
    check("oor_drop_cnt", 192'(drop_cnt), 192'(exp_drop));

    // ---- saturation
    force dut.drop_cnt_r = 32'hFFFF_FFFE;
    #1;
    release dut.drop_cnt_r;
    #1;
    check("sat_preset", 192'(drop_cnt), 192'(32'hFFFF_FFFE));
    @(negedge aclk);
    for (int k = 0; k < 2; k++) begin
      d = mk(16'h00F0 + 16'(k), 16'd6000, 32'h0);
      send(d, t);
      wait_to(t + 4);
      check("sat_drop_pulse", 192'(drop_pulse), 192'(1));
      wait_to(t + 5);
      check("sat_drop_cnt", 192'(drop_cnt), 192'(32'hFFFF_FFFF));
    end

    // ---- reset during lookup
    d = mk(16'h0ABC, 16'd5001, 32'hDEAD_BEEF);
    send(d, t);
    wait_to(t + 2);
    aresetn = 1'b0;
    @(negedge aclk);
    check("mrst_ready", 192'(s_ready), 192'(0));
    check("mrst_mvalid", 192'(m_valid), 192'(0));
    check("mrst_mdata", 192'(m_data), 192'(0));
    check("mrst_port_addr", 192'(port_addr), 192'(0));
    check("mrst_drop_pulse", 192'(drop_pulse), 192'(0));
    check("mrst_drop_cnt", 192'(drop_cnt), 192'(0));
    aresetn = 1'b1;
    for (int k = 4; k <= 12; k++) begin
      wait_to(t + k);
      check("mrst_after_mvalid", 192'(m_valid), 192'(0));
      check("mrst_after_drop", 192'(drop_pulse), 192'(0));
    end
    check("mrst_after_ready", 192'(s_ready), 192'(1));
    check("mrst_after_cnt", 192'(drop_cnt), 192'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
